// File: rtl/csa_pkg.sv
// csa_pkg: shared widths and FSM encoding for the 9-operand CSA loader.
package csa_pkg;
   localparam int WIDTH     = 16;
   localparam int NUM_OPS   = 9;
   localparam int SUM_WIDTH = 20;
   localparam int CNT_WIDTH = 4;
   localparam logic [1:0] FILL   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] OUTPUT = 2'd2;
endpackage

// File: rtl/csa9_operand_loader.sv
// csa9_operand_loader: collects up to nine operands for carry_save_adder_9 and returns its sum.
module csa9_operand_loader
   import csa_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic [WIDTH-1:0]     a0,
   output logic [WIDTH-1:0]     a1,
   output logic [WIDTH-1:0]     a2,
   output logic [WIDTH-1:0]     a3,
   output logic [WIDTH-1:0]     a4,
   output logic [WIDTH-1:0]     a5,
   output logic [WIDTH-1:0]     a6,
   output logic [WIDTH-1:0]     a7,
   output logic [WIDTH-1:0]     a8,
   input  logic [SUM_WIDTH-1:0] csa_sum,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SUM_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count
);
   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] idx_q, idx_d, out_count_q, out_count_d;
   logic [WIDTH-1:0]     slot_q [NUM_OPS];
   logic [WIDTH-1:0]     slot_d [NUM_OPS];
   logic [SUM_WIDTH-1:0] out_sum_q, out_sum_d;
   logic                 out_valid_q, out_valid_d, accept;
   assign in_ready  = (state_q == FILL);
   assign accept    = in_ready && in_valid;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign a0 = slot_q[0];
   assign a1 = slot_q[1];
   assign a2 = slot_q[2];
   assign a3 = slot_q[3];
   assign a4 = slot_q[4];
   assign a5 = slot_q[5];
   assign a6 = slot_q[6];
   assign a7 = slot_q[7];
   assign a8 = slot_q[8];
   // idx doubles as the frame count once FILL exits, so SETTLE reads it directly
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      slot_d      = slot_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         for (int i = 0; i < NUM_OPS; i++)
            slot_d[i] = (idx_q == CNT_WIDTH'(i)) ? in_data : slot_q[i];
         idx_d   = idx_q + CNT_WIDTH'(1);
         state_d = (in_last || idx_q == CNT_WIDTH'(NUM_OPS - 1)) ? SETTLE : FILL;
      end
      if (state_q == SETTLE) begin
         out_sum_d   = csa_sum;
         out_count_d = idx_q;
         out_valid_d = 1'b1;
         state_d     = OUTPUT;
      end
      // clearing the bank here keeps unused slots of the next frame at zero
      if (state_q == OUTPUT && out_ready) begin
         out_valid_d = 1'b0;
         slot_d      = '{default: '0};
         idx_d       = '0;
         state_d     = FILL;
      end
      if (state_q == 2'd3) state_d = FILL;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         idx_q       <= '0;
         slot_q      <= '{default: '0};
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         slot_q      <= slot_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule
